// File: rtl/md_defs.sv
// md_defs: op codes, FSM states and op-class helpers shared by the multiply/divide unit.
package md_defs;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;
  function automatic logic is_busy_op(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction
  function automatic logic is_div_op(input logic [2:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 32x32 multiply and divide producing HI/LO results plus a divide-by-zero flag.
module md_arith
  import md_defs::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div0_o
);
  logic        mul_s, div_s, div_op, neg_a, neg_b;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, dvs, quo, rem;
  assign mul_s  = op_i == MD_MULT;
  assign div_s  = op_i == MD_DIV;
  assign div_op = is_div_op(op_i);
  assign prod   = {{32{mul_s & a_i[31]}}, a_i} * {{32{mul_s & b_i[31]}}, b_i};
  // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN with a zero remainder
  assign neg_a  = div_s & a_i[31];
  assign neg_b  = div_s & b_i[31];
  assign mag_a  = neg_a ? -a_i : a_i;
  assign mag_b  = neg_b ? -b_i : b_i;
  assign dvs    = (b_i == 32'd0) ? 32'd1 : mag_b;
  assign quo    = mag_a / dvs;
  assign rem    = mag_a % dvs;
  assign div0_o = div_op && b_i == 32'd0;
  assign res_lo_o = div_op ? ((neg_a ^ neg_b) ? -quo : quo) : prod[31:0];
  assign res_hi_o = div_op ? (neg_a ? -rem : rem) : prod[63:32];
endmodule

// File: rtl/md_sched_unit.sv
// md_sched_unit: sequences the multi-cycle MD resource, owns HI/LO and raises the D-stage MD stall.
module md_sched_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        d_is_md_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        md_stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [31:0] res_hi, res_lo;
  logic        div0, go;
  md_arith u_arith (
    .op_i    (md_op_i),
    .a_i     (src_a_i),
    .b_i     (src_b_i),
    .res_hi_o(res_hi),
    .res_lo_o(res_lo),
    .div0_o  (div0)
  );
  assign go = start_i && is_busy_op(md_op_i);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (state_q == S_IDLE) begin
      if (go) begin
        state_d   = S_RUN;
        busy_d    = 1'b1;
        cnt_d     = is_div_op(md_op_i) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        // Divide by zero recommits the current HI/LO, leaving them unchanged
        pend_hi_d = div0 ? hi_q : res_hi;
        pend_lo_d = div0 ? lo_q : res_lo;
      end
      hi_d = (start_i && md_op_i == MD_MTHI) ? src_a_i : hi_q;
      lo_d = (start_i && md_op_i == MD_MTLO) ? src_a_i : lo_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        hi_d    = pend_hi_q;
        lo_d    = pend_lo_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign md_stall_o = d_is_md_i && (busy_q || go);
endmodule

// File: tb/tb_md_sched_unit.sv
// tb_md_sched_unit: directed checks of MD latency, HI/LO results, stall and reset behaviour.
module tb_md_sched_unit;
  logic        clk = 1'b0;
  logic        reset_n, start, d_is_md;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, done, md_stall;
  logic [31:0] hi, lo;
  int          total = 0;
  int          passed = 0;

  md_sched_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (start),
    .md_op_i   (md_op),
    .src_a_i   (src_a),
    .src_b_i   (src_b),
    .d_is_md_i (d_is_md),
    .busy_o    (busy),
    .done_o    (done),
    .md_stall_o(md_stall),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of cycle t0+1
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    #1;
    chk({tag, "_stall_start"}, 32'(md_stall), 32'(d_is_md && op >= 3'd1 && op <= 3'd4));
    tick();
    start = 1'b0;
    md_op = 3'd0;
  endtask

  task automatic expect_run(input string tag, input int n, input logic [31:0] eh, input logic [31:0] el);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      chk({tag, "_stall_busy"}, 32'(md_stall), 32'(d_is_md));
      tick();
    end
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_done"}, 32'(md_stall), 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    tick();
    chk({tag, "_done_clear"}, 32'(done), 32'd0);
    chk({tag, "_hi_hold"}, hi, eh);
    chk({tag, "_lo_hold"}, lo, el);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    d_is_md = 1'b1;
    md_op   = 3'd0;
    src_a   = '0;
    src_b   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", 32'(md_stall), 32'd0);
    reset_n = 1'b1;
    tick();
    d_is_md = 1'b0;

    issue("mult", 3'd1, 32'hFFFF_FFFE, 32'd3);
    expect_run("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    expect_run("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);

    issue("mult_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    expect_run("mult_min", 5, 32'h4000_0000, 32'h0000_0000);

    d_is_md = 1'b1;
    issue("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
    expect_run("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    d_is_md = 1'b0;

    issue("divu0", 3'd4, 32'd7, 32'd0);
    expect_run("divu0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue("mthi", 3'd5, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'hFFFF_FFFD);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_done", 32'(done), 32'd0);
    issue("mtlo", 3'd6, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi", hi, 32'h1234_5678);
    chk("mtlo_busy", 32'(busy), 32'd0);

    issue("none", 3'd0, 32'hDEAD_BEEF, 32'd1);
    chk("none_busy", 32'(busy), 32'd0);
    chk("none_hi", hi, 32'h1234_5678);
    issue("undef", 3'd7, 32'hDEAD_BEEF, 32'd1);
    chk("undef_busy", 32'(busy), 32'd0);
    chk("undef_lo", lo, 32'hCAFE_F00D);

    issue("ign", 3'd2, 32'd3, 32'd5);
    chk("ign_busy1", 32'(busy), 32'd1);
    start = 1'b1;
    md_op = 3'd1;
    src_a = 32'd7;
    src_b = 32'd9;
    tick();
    start = 1'b0;
    md_op = 3'd0;
    expect_run("ign", 4, 32'd0, 32'd15);
    chk("ign_idle", 32'(busy), 32'd0);

    issue("intmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_run("intmin", 10, 32'h0000_0000, 32'h8000_0000);

    issue("mthi2", 3'd5, 32'hA5A5_A5A5, 32'd0);
    chk("mthi2_hi", hi, 32'hA5A5_A5A5);

    d_is_md = 1'b1;
    issue("rst", 3'd3, 32'd100, 32'd7);
    tick();
    tick();
    chk("rst_mid_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_stall", 32'(md_stall), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("rst_post_done", 32'(done), 32'd0);
      chk("rst_post_busy", 32'(busy), 32'd0);
      chk("rst_post_lo", lo, 32'd0);
    end
    chk("rst_post_hi", hi, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
